// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: exception-bundle layout, load one-hot positions,
// and small extension helpers used by the memory stage and later AXI stages.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned RF_AW      = 5;
    localparam int unsigned CSR_NUM_W  = 14;
    localparam int unsigned EX_ZIP_W   = 86;
    localparam int unsigned EX_CAUSE_W = 7;
    localparam int unsigned LD_INST_W  = 5;

    // Exception-zip bit indices (low cause field)
    localparam int unsigned EX_ALE  = 0;
    localparam int unsigned EX_INE  = 1;
    localparam int unsigned EX_BRK  = 2;
    localparam int unsigned EX_SYS  = 3;
    localparam int unsigned EX_ADEF = 4;
    localparam int unsigned EX_INT  = 5;
    localparam int unsigned EX_ERTN = 6;

    // es_ld_inst one-hot bit positions
    localparam int unsigned LD_B    = 4;
    localparam int unsigned LD_BU   = 3;
    localparam int unsigned LD_H    = 2;
    localparam int unsigned LD_HU   = 1;
    localparam int unsigned LD_WORD = 0;

    // Exception bundle, MSB first
    typedef struct packed {
        logic                 csr_we;
        logic [XLEN-1:0]      csr_wmask;
        logic [XLEN-1:0]      csr_wvalue;
        logic [CSR_NUM_W-1:0] csr_num;
        logic                 ertn;
        logic                 has_int;
        logic                 adef;
        logic                 sys;
        logic                 brk;
        logic                 ine;
        logic                 ale;
    } ex_zip_t;

    // Byte to word, signed or unsigned
    function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
        return {{(XLEN-8){sgn & b[7]}}, b};
    endfunction

    // Halfword to word, signed or unsigned
    function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
        return {{(XLEN-16){sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX -> MS pipeline link: EX payload plus the MS allow-in back-pressure.
interface mem_stage_if;
    import cpu_pkg::*;

    logic                  es_to_ms_valid;
    logic [XLEN-1:0]       es_pc;
    logic                  es_rf_we;
    logic [RF_AW-1:0]      es_rf_waddr;
    logic [XLEN-1:0]       es_result;
    logic                  es_res_from_mem;
    logic [LD_INST_W-1:0]  es_ld_inst;
    logic                  es_csr_re;
    logic [EX_ZIP_W-1:0]   es_ex_zip;
    logic                  ms_allowin;

    // EX side drives the payload
    modport master (
        output es_to_ms_valid, es_pc, es_rf_we, es_rf_waddr, es_result,
               es_res_from_mem, es_ld_inst, es_csr_re, es_ex_zip,
        input  ms_allowin
    );

    // MS side consumes the payload
    modport slave (
        input  es_to_ms_valid, es_pc, es_rf_we, es_rf_waddr, es_result,
               es_res_from_mem, es_ld_inst, es_csr_re, es_ex_zip,
        output ms_allowin
    );

endinterface

// File: rtl/load_align.sv
// Combinational load data select and sign/zero extension from a 32-bit word.
module load_align
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0]      raw_i,
    input  logic [1:0]           addr_i,
    input  logic [LD_INST_W-1:0] ld_inst_i,
    output logic [XLEN-1:0]      result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword
    always_comb begin
        byte_sel = raw_i[7:0];
        case (addr_i)
            2'd0:    byte_sel = raw_i[7:0];
            2'd1:    byte_sel = raw_i[15:8];
            2'd2:    byte_sel = raw_i[23:16];
            default: byte_sel = raw_i[31:24];
        endcase
        half_sel = addr_i[1] ? raw_i[31:16] : raw_i[15:0];
    end

    // Extend according to the load type; non-loads see the raw word
    always_comb begin
        result_o = raw_i;
        if (ld_inst_i[LD_B]) begin
            result_o = ext8(byte_sel, 1'b1);
        end else if (ld_inst_i[LD_BU]) begin
            result_o = ext8(byte_sel, 1'b0);
        end else if (ld_inst_i[LD_H]) begin
            result_o = ext16(half_sel, 1'b1);
        end else if (ld_inst_i[LD_HU]) begin
            result_o = ext16(half_sel, 1'b0);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX and WB: latches the EX payload,
// buffers the one-cycle SRAM read data across WB stalls, aligns load data and
// exposes GR write / forwarding info.
// Optional: define MS_FWD_EN to let ID bypass from this stage (ms_fwd_valid).
module mem_stage
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ws_allowin,
    mem_stage_if.slave           es_if,
    input  logic [XLEN-1:0]      data_sram_rdata,
    input  logic                 wb_ex,
    output logic                 ms_to_ws_valid,
    output logic [XLEN-1:0]      ms_pc,
    output logic                 ms_rf_we,
    output logic [RF_AW-1:0]     ms_rf_waddr,
    output logic [XLEN-1:0]      ms_rf_wdata,
    output logic                 ms_csr_re,
    output logic [EX_ZIP_W-1:0]  ms_ex_zip,
    output logic                 ms_ex,
    output logic                 ms_fwd_valid
);

    logic                 ms_valid_q,        ms_valid_d;
    logic                 ms_fresh_q,        ms_fresh_d;
    logic                 hold_v_q,          hold_v_d;
    logic [XLEN-1:0]      rdata_hold_q,      rdata_hold_d;
    logic [XLEN-1:0]      ms_pc_q,           ms_pc_d;
    logic                 ms_rf_we_q,        ms_rf_we_d;
    logic [RF_AW-1:0]     ms_rf_waddr_q,     ms_rf_waddr_d;
    logic [XLEN-1:0]      ms_result_q,       ms_result_d;
    logic                 ms_res_from_mem_q, ms_res_from_mem_d;
    logic [LD_INST_W-1:0] ms_ld_inst_q,      ms_ld_inst_d;
    logic                 ms_csr_re_q,       ms_csr_re_d;
    ex_zip_t              ms_ex_zip_q,       ms_ex_zip_d;

    logic            allowin;
    logic            accept;
    logic            transfer;
    logic            has_ex;
    logic [XLEN-1:0] raw_rdata;
    logic [XLEN-1:0] load_data;

    // Handshake: single-cycle stage, a flush always empties it
    assign allowin        = !ms_valid_q | ws_allowin | wb_ex;
    assign accept         = es_if.es_to_ms_valid & allowin;
    assign ms_to_ws_valid = ms_valid_q & ~wb_ex;
    assign transfer       = ms_to_ws_valid & ws_allowin;
    assign es_if.ms_allowin = allowin;

    // Any cause bit or ertn marks the instruction as excepting
    assign has_ex = ms_ex_zip_q.ale  | ms_ex_zip_q.ine     | ms_ex_zip_q.brk  |
                    ms_ex_zip_q.sys  | ms_ex_zip_q.adef    | ms_ex_zip_q.has_int |
                    ms_ex_zip_q.ertn;

    // SRAM data is live only in the first cycle; afterwards use the hold copy
    assign raw_rdata = hold_v_q ? rdata_hold_q : data_sram_rdata;

    load_align u_load_align (
        .raw_i     (raw_rdata),
        .addr_i    (ms_result_q[1:0]),
        .ld_inst_i (ms_ld_inst_q),
        .result_o  (load_data)
    );

    // Next-state: valid/fresh tracking, payload capture and read-data hold
    always_comb begin
        ms_valid_d        = ms_valid_q;
        ms_fresh_d        = 1'b0;
        hold_v_d          = hold_v_q;
        rdata_hold_d      = rdata_hold_q;
        ms_pc_d           = ms_pc_q;
        ms_rf_we_d        = ms_rf_we_q;
        ms_rf_waddr_d     = ms_rf_waddr_q;
        ms_result_d       = ms_result_q;
        ms_res_from_mem_d = ms_res_from_mem_q;
        ms_ld_inst_d      = ms_ld_inst_q;
        ms_csr_re_d       = ms_csr_re_q;
        ms_ex_zip_d       = ms_ex_zip_q;

        if (wb_ex) begin
            ms_valid_d = 1'b0;
        end else if (allowin) begin
            ms_valid_d = es_if.es_to_ms_valid;
        end

        if (accept) begin
            ms_fresh_d        = ~wb_ex;
            ms_pc_d           = es_if.es_pc;
            ms_rf_we_d        = es_if.es_rf_we;
            ms_rf_waddr_d     = es_if.es_rf_waddr;
            ms_result_d       = es_if.es_result;
            ms_res_from_mem_d = es_if.es_res_from_mem;
            ms_ld_inst_d      = es_if.es_ld_inst;
            ms_csr_re_d       = es_if.es_csr_re;
            ms_ex_zip_d       = ex_zip_t'(es_if.es_ex_zip);
        end

        // A stall in the first cycle would lose the SRAM data, so keep a copy
        if (wb_ex | transfer) begin
            hold_v_d = 1'b0;
        end else if (ms_fresh_q & ~ws_allowin) begin
            hold_v_d     = 1'b1;
            rdata_hold_d = data_sram_rdata;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q        <= 1'b0;
            ms_fresh_q        <= 1'b0;
            hold_v_q          <= 1'b0;
            rdata_hold_q      <= '0;
            ms_pc_q           <= '0;
            ms_rf_we_q        <= 1'b0;
            ms_rf_waddr_q     <= '0;
            ms_result_q       <= '0;
            ms_res_from_mem_q <= 1'b0;
            ms_ld_inst_q      <= '0;
            ms_csr_re_q       <= 1'b0;
            ms_ex_zip_q       <= '0;
        end else begin
            ms_valid_q        <= ms_valid_d;
            ms_fresh_q        <= ms_fresh_d;
            hold_v_q          <= hold_v_d;
            rdata_hold_q      <= rdata_hold_d;
            ms_pc_q           <= ms_pc_d;
            ms_rf_we_q        <= ms_rf_we_d;
            ms_rf_waddr_q     <= ms_rf_waddr_d;
            ms_result_q       <= ms_result_d;
            ms_res_from_mem_q <= ms_res_from_mem_d;
            ms_ld_inst_q      <= ms_ld_inst_d;
            ms_csr_re_q       <= ms_csr_re_d;
            ms_ex_zip_q       <= ms_ex_zip_d;
        end
    end

    // Outputs to WB; an excepting instruction never writes the GR file
    assign ms_pc       = ms_pc_q;
    assign ms_ex       = ms_valid_q & has_ex;
    assign ms_rf_we    = ms_valid_q & ms_rf_we_q & ~ms_ex;
    assign ms_rf_waddr = ms_rf_waddr_q;
    assign ms_rf_wdata = ms_res_from_mem_q ? load_data : ms_result_q;
    assign ms_csr_re   = ms_csr_re_q;
    assign ms_ex_zip   = EX_ZIP_W'(ms_ex_zip_q);

`ifdef MS_FWD_EN
    // ID may bypass the write data, including aligned load data
    assign ms_fwd_valid = ms_valid_q & ms_rf_we_q & ~ms_ex;
`else
    // No bypass: ID stalls on any MS write-address match
    assign ms_fwd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load alignment, WB stall hold, ALU path,
// exceptions, wb_ex flush, back-to-back entry and reset during a stall.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        wb_ex;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic        ms_csr_re;
    logic [85:0] ms_ex_zip;
    logic        ms_ex;
    logic        ms_fwd_valid;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef MS_FWD_EN
    localparam logic FWD_EXP = 1'b1;
`else
    localparam logic FWD_EXP = 1'b0;
`endif

    localparam logic [4:0] OH_B  = 5'b10000;
    localparam logic [4:0] OH_BU = 5'b01000;
    localparam logic [4:0] OH_H  = 5'b00100;
    localparam logic [4:0] OH_HU = 5'b00010;
    localparam logic [4:0] OH_W  = 5'b00001;

    mem_stage_if es_if ();

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .es_if           (es_if),
        .data_sram_rdata (data_sram_rdata),
        .wb_ex           (wb_ex),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_pc           (ms_pc),
        .ms_rf_we        (ms_rf_we),
        .ms_rf_waddr     (ms_rf_waddr),
        .ms_rf_wdata     (ms_rf_wdata),
        .ms_csr_re       (ms_csr_re),
        .ms_ex_zip       (ms_ex_zip),
        .ms_ex           (ms_ex),
        .ms_fwd_valid    (ms_fwd_valid)
    );

    always #5 clk = ~clk;

    task automatic present(input logic [31:0] pc, input logic rf_we, input logic [4:0] waddr,
                           input logic [31:0] result, input logic from_mem, input logic [4:0] ld,
                           input logic csr_re, input logic [85:0] zip);
        es_if.es_to_ms_valid  = 1'b1;
        es_if.es_pc           = pc;
        es_if.es_rf_we        = rf_we;
        es_if.es_rf_waddr     = waddr;
        es_if.es_result       = result;
        es_if.es_res_from_mem = from_mem;
        es_if.es_ld_inst      = ld;
        es_if.es_csr_re       = csr_re;
        es_if.es_ex_zip       = zip;
    endtask

    task automatic idle_es();
        es_if.es_to_ms_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ws_allowin = 1'b1; wb_ex = 1'b0; data_sram_rdata = 32'h0;
        idle_es();
        present(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 86'h0);
        idle_es();
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        n_cmp++; if (ms_allowin_w() !== 1'b1) begin n_fail++; $display("FAIL reset_allowin got %0b want 1", ms_allowin_w()); end
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", ms_to_ws_valid); end
        n_cmp++; if (ms_rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", ms_rf_wdata); end
        n_cmp++; if ({ms_pc, ms_rf_we, ms_rf_waddr, ms_csr_re, ms_ex, ms_fwd_valid} !== 41'h0) begin
            n_fail++; $display("FAIL reset_misc got pc=%h we=%0b wa=%0d csr=%0b ex=%0b fwd=%0b want all 0",
                               ms_pc, ms_rf_we, ms_rf_waddr, ms_csr_re, ms_ex, ms_fwd_valid); end
        n_cmp++; if (ms_ex_zip !== 86'h0) begin n_fail++; $display("FAIL reset_zip got %h want 0", ms_ex_zip); end
    endtask

    function automatic logic ms_allowin_w();
        return es_if.ms_allowin;
    endfunction

    task automatic test_load_extract();
        logic [4:0]  ld  [7] = '{OH_B, OH_BU, OH_H, OH_W, OH_HU, OH_B, OH_H};
        logic [1:0]  ad  [7] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3, 2'd0};
        logic [31:0] ex  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1234, 32'h1234_80FF,
                                 32'h0000_80FF, 32'h0000_0012, 32'hFFFF_80FF};
        @(negedge clk);
        ws_allowin = 1'b1;
        for (int i = 0; i < 7; i++) begin
            present(32'h1C00_0000 + 32'(i * 4), 1'b1, 5'd7, {30'h0400_0000, ad[i]}, 1'b1, ld[i], 1'b0, 86'h0);
            @(posedge clk);
            @(negedge clk);
            idle_es();
            data_sram_rdata = 32'h1234_80FF;
            #1;
            n_cmp++; if (ms_rf_wdata !== ex[i]) begin n_fail++; $display("FAIL load_extract[%0d] got %h want %h", i, ms_rf_wdata, ex[i]); end
            n_cmp++; if ({ms_to_ws_valid, ms_rf_we, ms_rf_waddr} !== {1'b1, 1'b1, 5'd7}) begin
                n_fail++; $display("FAIL load_ctrl[%0d] got v=%0b we=%0b wa=%0d want 1 1 7", i, ms_to_ws_valid, ms_rf_we, ms_rf_waddr); end
        end
        @(negedge clk);
    endtask

    task automatic test_stall_hold();
        @(negedge clk);
        ws_allowin = 1'b1;
        present(32'h1C00_0100, 1'b1, 5'd9, 32'h2000_0000, 1'b1, OH_W, 1'b0, 86'h0);
        @(posedge clk);
        @(negedge clk);
        idle_es();
        data_sram_rdata = 32'h1234_80FF;
        ws_allowin = 1'b0;
        #1;
        n_cmp++; if (ms_rf_wdata !== 32'h1234_80FF) begin n_fail++; $display("FAIL stall_first got %h want 123480ff", ms_rf_wdata); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            data_sram_rdata = 32'hDEAD_BEEF;
            #1;
            n_cmp++; if (ms_rf_wdata !== 32'h1234_80FF) begin n_fail++; $display("FAIL stall_hold[%0d] got %h want 123480ff", k, ms_rf_wdata); end
            n_cmp++; if ({ms_to_ws_valid, dut.hold_v_q} !== 2'b11) begin
                n_fail++; $display("FAIL stall_state[%0d] got v=%0b hold=%0b want 1 1", k, ms_to_ws_valid, dut.hold_v_q); end
        end
        ws_allowin = 1'b1;
        #1;
        n_cmp++; if (ms_rf_wdata !== 32'h1234_80FF) begin n_fail++; $display("FAIL stall_release got %h want 123480ff", ms_rf_wdata); end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++; if ({ms_to_ws_valid, dut.hold_v_q} !== 2'b00) begin
            n_fail++; $display("FAIL stall_after got v=%0b hold=%0b want 0 0", ms_to_ws_valid, dut.hold_v_q); end
    endtask

    task automatic test_alu();
        @(negedge clk);
        ws_allowin = 1'b1;
        present(32'h1C00_0200, 1'b1, 5'd5, 32'h0000_0042, 1'b0, 5'd0, 1'b1, 86'h0);
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL alu_early got %0b want 0", ms_to_ws_valid); end
        @(posedge clk);
        @(negedge clk);
        idle_es();
        data_sram_rdata = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (ms_rf_wdata !== 32'h0000_0042) begin n_fail++; $display("FAIL alu_wdata got %h want 00000042", ms_rf_wdata); end
        n_cmp++; if ({ms_to_ws_valid, ms_rf_we, ms_rf_waddr, ms_csr_re} !== {1'b1, 1'b1, 5'd5, 1'b1}) begin
            n_fail++; $display("FAIL alu_ctrl got v=%0b we=%0b wa=%0d csr=%0b want 1 1 5 1",
                               ms_to_ws_valid, ms_rf_we, ms_rf_waddr, ms_csr_re); end
        n_cmp++; if (ms_pc !== 32'h1C00_0200) begin n_fail++; $display("FAIL alu_pc got %h want 1c000200", ms_pc); end
        n_cmp++; if (ms_fwd_valid !== FWD_EXP) begin n_fail++; $display("FAIL alu_fwd got %0b want %0b", ms_fwd_valid, FWD_EXP); end
    endtask

    task automatic test_exception();
        logic [85:0] zip;
        zip = {1'b1, 32'hA5A5_0F0F, 32'h1234_5678, 14'h0123, 7'b000_1000};
        @(negedge clk);
        ws_allowin = 1'b1;
        present(32'h1C00_0300, 1'b1, 5'd3, 32'h0000_0010, 1'b0, 5'd0, 1'b0, zip);
        @(posedge clk);
        @(negedge clk);
        idle_es();
        #1;
        n_cmp++; if ({ms_ex, ms_rf_we, ms_fwd_valid} !== 3'b100) begin
            n_fail++; $display("FAIL exc_flags got ex=%0b we=%0b fwd=%0b want 1 0 0", ms_ex, ms_rf_we, ms_fwd_valid); end
        n_cmp++; if (ms_ex_zip !== zip) begin n_fail++; $display("FAIL exc_zip got %h want %h", ms_ex_zip, zip); end
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL exc_valid got %0b want 1", ms_to_ws_valid); end
    endtask

    task automatic test_wb_ex();
        @(negedge clk);
        ws_allowin = 1'b1;
        present(32'h1C00_0400, 1'b1, 5'd11, 32'h3000_0000, 1'b1, OH_W, 1'b0, 86'h0);
        @(posedge clk);
        @(negedge clk);
        idle_es();
        data_sram_rdata = 32'hCAFE_F00D;
        ws_allowin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        data_sram_rdata = 32'h0BAD_0BAD;
        #1;
        n_cmp++; if (dut.hold_v_q !== 1'b1) begin n_fail++; $display("FAIL wbex_pre_hold got %0b want 1", dut.hold_v_q); end
        wb_ex = 1'b1;
        present(32'h1C00_0404, 1'b1, 5'd12, 32'h0000_0001, 1'b0, 5'd0, 1'b0, 86'h0);
        #1;
        n_cmp++; if ({ms_to_ws_valid, ms_allowin_w()} !== 2'b01) begin
            n_fail++; $display("FAIL wbex_same got v=%0b allowin=%0b want 0 1", ms_to_ws_valid, ms_allowin_w()); end
        @(posedge clk);
        @(negedge clk);
        wb_ex = 1'b0;
        idle_es();
        #1;
        n_cmp++; if ({ms_to_ws_valid, dut.hold_v_q, ms_allowin_w(), ms_rf_we} !== 4'b0010) begin
            n_fail++; $display("FAIL wbex_next got v=%0b hold=%0b allowin=%0b we=%0b want 0 0 1 0",
                               ms_to_ws_valid, dut.hold_v_q, ms_allowin_w(), ms_rf_we); end
        ws_allowin = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        ws_allowin = 1'b1;
        present(32'h1C00_0500, 1'b1, 5'd13, 32'h4000_0000, 1'b1, OH_W, 1'b0, 86'h0);
        @(posedge clk);
        @(negedge clk);
        idle_es();
        data_sram_rdata = 32'h1111_2222;
        ws_allowin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        data_sram_rdata = 32'h9999_9999;
        ws_allowin = 1'b1;
        present(32'h1C00_0504, 1'b1, 5'd14, 32'h4000_0003, 1'b1, OH_BU, 1'b0, 86'h0);
        #1;
        n_cmp++; if (ms_rf_wdata !== 32'h1111_2222) begin n_fail++; $display("FAIL b2b_first got %h want 11112222", ms_rf_wdata); end
        @(posedge clk);
        @(negedge clk);
        idle_es();
        data_sram_rdata = 32'hAB00_0000;
        #1;
        n_cmp++; if (ms_rf_wdata !== 32'h0000_00AB) begin n_fail++; $display("FAIL b2b_second got %h want 000000ab", ms_rf_wdata); end
        n_cmp++; if ({ms_pc, ms_rf_waddr, dut.hold_v_q, ms_to_ws_valid} !== {32'h1C00_0504, 5'd14, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL b2b_state got pc=%h wa=%0d hold=%0b v=%0b want 1c000504 14 0 1",
                               ms_pc, ms_rf_waddr, dut.hold_v_q, ms_to_ws_valid); end
    endtask

    task automatic test_reset_stall();
        @(negedge clk);
        ws_allowin = 1'b1;
        present(32'h1C00_0600, 1'b1, 5'd15, 32'h5000_0000, 1'b1, OH_W, 1'b1, 86'h1);
        @(posedge clk);
        @(negedge clk);
        idle_es();
        data_sram_rdata = 32'h55AA_33CC;
        ws_allowin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        data_sram_rdata = 32'h7777_7777;
        #1;
        n_cmp++; if ({ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata, ms_csr_re, ms_ex, ms_fwd_valid} !== 73'h0) begin
            n_fail++; $display("FAIL rst_stall_out got v=%0b pc=%h we=%0b wa=%0d wd=%h csr=%0b ex=%0b fwd=%0b want all 0",
                               ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata, ms_csr_re, ms_ex, ms_fwd_valid); end
        n_cmp++; if (ms_ex_zip !== 86'h0) begin n_fail++; $display("FAIL rst_stall_zip got %h want 0", ms_ex_zip); end
        n_cmp++; if ({ms_allowin_w(), dut.hold_v_q} !== 2'b10) begin
            n_fail++; $display("FAIL rst_stall_state got allowin=%0b hold=%0b want 1 0", ms_allowin_w(), dut.hold_v_q); end
        ws_allowin = 1'b1;
        present(32'h1C00_0700, 1'b1, 5'd16, 32'h5000_0002, 1'b1, OH_HU, 1'b0, 86'h0);
        @(posedge clk);
        @(negedge clk);
        idle_es();
        data_sram_rdata = 32'hF00D_0000;
        #1;
        n_cmp++; if (ms_rf_wdata !== 32'h0000_F00D) begin n_fail++; $display("FAIL rst_stall_next got %h want 0000f00d", ms_rf_wdata); end
    endtask

    initial begin
        test_reset();
        test_load_extract();
        test_stall_hold();
        test_alu();
        test_exception();
        test_wb_ex();
        test_back_to_back();
        test_reset_stall();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access (MS) stage of the five-stage LoongArch pipeline, between EX and WB. It accepts the EX result and its exception bundle, then takes the synchronous data-SRAM read data one cycle after EX issued the access. Load data is byte/halfword-selected and sign- or zero-extended, held if WB stalls, and handed to WB with exception status. MS also drives the register-write forwarding and hazard information back to ID.

## Interface
- No parameters.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `ws_allowin` in 1: WB can accept this cycle.
- `ms_allowin` out 1: MS can accept this cycle.
- `es_to_ms_valid` in 1: EX presents a valid instruction.
- `es_pc` in 32: EX PC.
- `es_rf_we` in 1, `es_rf_waddr` in 5: GR write enable and address.
- `es_result` in 32: ALU/counter result; this is the memory address for loads and stores.
- `es_res_from_mem` in 1: instruction is a load.
- `es_ld_inst` in 5: one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}, bit 4..0.
- `es_csr_re` in 1: CSR read instruction.
- `es_ex_zip` in 86: {csr_we, csr_wmask[31:0], csr_wvalue[31:0], csr_num[13:0], ertn, has_int, adef, sys, brk, ine, ale}, MSB first.
- `data_sram_rdata` in 32: valid only in the cycle after EX issued the access.
- `wb_ex` in 1: WB flush (exception or ertn).
- `ms_to_ws_valid` out 1.
- `ms_pc` out 32.
- `ms_rf_we` out 1, `ms_rf_waddr` out 5, `ms_rf_wdata` out 32.
- `ms_csr_re` out 1.
- `ms_ex_zip` out 86: latched bundle plus ms_badv is not added; ale is carried unchanged.
- `ms_ex` out 1: MS holds an excepting or ertn instruction.
- `ms_fwd_valid` out 1: ms_rf_we/waddr/wdata are valid for forwarding to ID.

## Operation
- Registers:
  - `ms_valid`.
  - Payload registers, one per `es_*` input.
  - `ms_fresh`: this is the first cycle after entry.
  - `rdata_hold`: 32 bits.
  - `hold_v`.
- Entry: when `es_to_ms_valid && ms_allowin`, latch the payload and set `ms_fresh`=1. In all other cycles `ms_fresh`=0.
- `ms_valid`:
  - 0 on reset.
  - Else 0 if `wb_ex`.
  - Else, if `ms_allowin`, it takes `es_to_ms_valid`.
- Ready: `ms_ready_go`=1.
- `ms_allowin` = !ms_valid | (ws_allowin & ~wb_ex) | wb_ex.
- `ms_to_ws_valid` = ms_valid & ~wb_ex.
- Read-data buffer:
  - raw = hold_v ? rdata_hold : data_sram_rdata.
  - If `ms_fresh & ~ws_allowin`, capture `data_sram_rdata` into `rdata_hold` and set `hold_v`.
  - Clear `hold_v` on the MS→WB transfer, on `wb_ex`, and on reset.
- Load extract, with a = ms_result[1:0]:
  - ld_w: raw.
  - ld_h/hu: raw half at a[1], sign- or zero-extended.
  - ld_b/bu: raw byte at a, sign- or zero-extended.
- `ms_rf_wdata` = ms_res_from_mem ? extracted : ms_result.
- `ms_ex` = ms_valid & (|ms_ex_zip[6:0]).
- `ms_rf_we` = ms_valid & ms_rf_we_reg & ~ms_ex. An excepting instruction never writes the GR file.
- `ms_ex_zip` passes through as latched.
- Stores, and loads that raised ale in EX: the data is don't-care and is never written.

## Timing
- Reset values:
  - All payload registers, `ms_valid`, `ms_fresh` and `hold_v` are 0.
  - Therefore every output is 0, except `ms_allowin`=1.
- Latency: one cycle. An instruction accepted at edge N is presented to WB from cycle N+1. Load data comes from SRAM in cycle N+1, or from the hold register after that.
- WB stall: the output is stable and `ms_rf_wdata` is unchanged for any stall length, even though `data_sram_rdata` changes after N+1.
- `wb_ex`:
  - In the same cycle `ms_to_ws_valid`=0.
  - At the next edge MS is empty and `hold_v`=0.
  - If `es_to_ms_valid` is high in that cycle it is discarded; EX is flushed by the same `wb_ex`.
- Back-to-back: entry and exit in the same cycle give a new payload, `ms_fresh`=1, `hold_v`=0.
- `reset` mid-stall discards the held data.

## Configuration
- `MS_FWD_EN` defined:
  - `ms_fwd_valid` = ms_valid & ms_rf_we_reg & ~ms_ex.
  - ID bypasses `ms_rf_wdata`, including load data.
- `MS_FWD_EN` undefined:
  - `ms_fwd_valid` is tied to 0.
  - ID must stall on any MS write-address match.
  - `ms_rf_we/waddr/wdata` remain driven for WB.

## Structure
- Shared package `cpu_pkg`:
  - Exception-zip width (86) and the bit indices: ALE=0, INE=1, BRK=2, SYS=3, ADEF=4, INT=5, ERTN=6.
  - `es_ld_inst` bit positions.
- Sub-module `load_align`: purely combinational raw data + a[1:0] + ld one-hot → 32-bit result. Reused by later AXI stages.

## Test plan
- ld.b with a=1, rdata 0x1234_80FF → `ms_rf_wdata`=0xFFFF_FF80. ld.bu → 0x0000_0080. ld.h with a=2 → 0x0000_1234. ld.w → 0x1234_80FF.
- ld.w accepted, then `ws_allowin`=0 for 3 cycles while rdata changes to 0xDEAD_BEEF after N+1 → output stays 0x1234_80FF until transfer, and `hold_v` clears after it.
- Non-load add with es_result 0x0000_0042, rf_waddr 5 → WB receives wdata 0x42, waddr 5 one cycle later. `ms_fwd_valid`=1 only when `MS_FWD_EN` is defined.
- es_ex_zip with sys=1 and rf_we=1 → `ms_ex`=1, `ms_rf_we`=0, `ms_ex_zip` matches the input bit-for-bit.
- `wb_ex` pulse while MS holds a stalled load → `ms_to_ws_valid`=0 the same cycle, `ms_valid`=0 and `hold_v`=0 the next cycle, `ms_allowin`=1.
- `reset` asserted during a stall → all outputs 0 the next cycle and `ms_allowin`=1.
